// File: rtl/max_pooling_layer_param.sv
// Streaming POOLxPOOL / stride-POOL max pooling over CHANNELS parallel lanes.
// Keeps only a horizontal running max and one band row of OW partial maxima per lane.
module max_pool_lane #(
   parameter int DATA_W = 1,
   parameter int SIGNED = 0,
   parameter int IW     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              acc,
   input  logic              first_col,
   input  logic              last_col,
   input  logic              first_row,
   input  logic              emit,
   input  logic [IW-1:0]     idx,
   input  logic [DATA_W-1:0] pix,
   output logic [DATA_W-1:0] pool
);

   logic [DATA_W-1:0] h_acc;
   logic [DATA_W-1:0] band [2**IW];
   logic [DATA_W-1:0] h_max;
   logic [DATA_W-1:0] g_max;

   function automatic logic [DATA_W-1:0] vmax(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
      else             return (a > b) ? a : b;
   endfunction

   always_comb begin
      h_max = first_col ? pix : vmax(h_acc, pix);
      g_max = first_row ? h_max : vmax(band[idx], h_max);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_acc <= '0;
         pool  <= '0;
         for (int i = 0; i < 2**IW; i++) band[i] <= '0;
      end else if (acc) begin
         h_acc <= h_max;
         if (last_col) band[idx] <= g_max;
         if (emit)     pool      <= g_max;
      end
   end

endmodule

module max_pooling_layer_param #(
   parameter int CHANNELS = 16,
   parameter int DATA_W   = 1,
   parameter int SIGNED   = 0,
   parameter int WIDTH    = 11,
   parameter int HEIGHT   = 11,
   parameter int POOL     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sof,
   input  logic                       valid_in,
   input  logic [CHANNELS*DATA_W-1:0] pixel_in,
   output logic [CHANNELS*DATA_W-1:0] pool_out,
   output logic                       valid_out,
   output logic                       frame_done
);

   localparam int OW  = WIDTH / POOL;
   localparam int OH  = HEIGHT / POOL;
   localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int GW  = $clog2(OW + 1);
   localparam int BW  = $clog2(OH + 1);
   localparam int PW  = $clog2(POOL);
   localparam int IW  = (OW > 1) ? $clog2(OW) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(POOL - 1);
   localparam logic [GW-1:0] OW_L      = GW'(OW);
   localparam logic [BW-1:0] OH_L      = BW'(OH);
   localparam logic [GW-1:0] GRP_LAST  = GW'(OW - 1);
   localparam logic [BW-1:0] BAND_LAST = BW'(OH - 1);

   // gidx/band index the output grid; they run one past it in the ignored margin
   logic [CW-1:0] col,  e_col;
   logic [RW-1:0] row,  e_row;
   logic [PW-1:0] cpos, e_cpos;
   logic [PW-1:0] rpos, e_rpos;
   logic [GW-1:0] gidx, e_gidx;
   logic [BW-1:0] band, e_band;

   logic col_end, row_end, grp_end, bnd_end;
   logic in_region, acc, emit, last_out;

   // sof restarts the frame on this very beat, so it overrides the counters combinationally
   always_comb begin
      e_col     = sof ? '0 : col;
      e_row     = sof ? '0 : row;
      e_cpos    = sof ? '0 : cpos;
      e_rpos    = sof ? '0 : rpos;
      e_gidx    = sof ? '0 : gidx;
      e_band    = sof ? '0 : band;
      col_end   = (e_col == COL_LAST);
      row_end   = (e_row == ROW_LAST);
      grp_end   = (e_cpos == POS_LAST);
      bnd_end   = (e_rpos == POS_LAST);
      in_region = (e_gidx < OW_L) && (e_band < OH_L);
      acc       = valid_in && in_region;
      emit      = acc && grp_end && bnd_end;
      last_out  = emit && (e_gidx == GRP_LAST) && (e_band == BAND_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col  <= '0;
         row  <= '0;
         cpos <= '0;
         rpos <= '0;
         gidx <= '0;
         band <= '0;
      end else if (valid_in) begin
         if (col_end) begin
            col  <= '0;
            cpos <= '0;
            gidx <= '0;
            row  <= row_end ? '0 : e_row + 1'b1;
            rpos <= (row_end || bnd_end) ? '0 : e_rpos + 1'b1;
            band <= row_end ? '0 : (bnd_end ? e_band + 1'b1 : e_band);
         end else begin
            col  <= e_col + 1'b1;
            cpos <= grp_end ? '0 : e_cpos + 1'b1;
            gidx <= grp_end ? e_gidx + 1'b1 : e_gidx;
            row  <= e_row;
            rpos <= e_rpos;
            band <= e_band;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= emit;
         frame_done <= last_out;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      max_pool_lane #(
         .DATA_W (DATA_W),
         .SIGNED (SIGNED),
         .IW     (IW)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .acc       (acc),
         .first_col (e_cpos == '0),
         .last_col  (grp_end),
         .first_row (e_rpos == '0),
         .emit      (emit),
         .idx       (e_gidx[IW-1:0]),
         .pix       (pixel_in[c*DATA_W +: DATA_W]),
         .pool      (pool_out[c*DATA_W +: DATA_W])
      );
   end

endmodule
